matmul_row_scheduler: RTL

Sequences the 3x3 matrix multiply controller row by row. For each row it drives the controller's start/which_row handshake and waits for the row-complete indication. It reports overall completion, progress, elapsed cycles and timeout/abort status to the host.
It sits between the host control logic and the matrix multiply controller, and is the only driver of the controller's start and which_row inputs.

---
 rtl/matmul_row_scheduler.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/matmul_row_scheduler.sv
// matmul_row_scheduler
//
// Walks the 3x3 matrix multiply controller through its result rows one at a
// time. For each row it raises ctrl_start with the row index on
// ctrl_which_row. It waits for the controller to drop ctrl_done as an
// acknowledge, and then waits for ctrl_done to rise again as row-complete.
// After each row, ctrl_start is released for a fixed number of cycles so the
// controller sees a clean start edge for the next row.
//
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous, active-high reset
//   go              start a full multiply (accepted only when idle)
//   abort           cancel the running operation (ignored when idle)
//   num_rows        rows to compute from row 0, clamped to MAX_ROWS, latched on go
//   ctrl_done       row-complete level from the controller
//   ctrl_start      start level to the controller
//   ctrl_which_row  row index to the controller, stable while ctrl_start is high
//   busy            high whenever an operation is in progress
//   all_done        one-cycle pulse after the last row has completed
//   rows_completed  rows finished in the current or last operation
//   cycle_count     busy cycles in the current or last operation (saturating)
//   timeout_err     sticky: the controller failed to respond in time
//   aborted         sticky: the last operation was aborted
module matmul_row_scheduler #(
    parameter int MAX_ROWS       = 3,
    parameter int RELEASE_CYCLES = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             abort,
    input  logic [3:0]       num_rows,
    input  logic             ctrl_done,
    output logic             ctrl_start,
    output logic [3:0]       ctrl_which_row,
    output logic             busy,
    output logic             all_done,
    output logic [3:0]       rows_completed,
    output logic [CNT_W-1:0] cycle_count,
    output logic             timeout_err,
    output logic             aborted
);

    localparam int SEQ_MAX = (TIMEOUT_CYCLES > RELEASE_CYCLES) ? TIMEOUT_CYCLES : RELEASE_CYCLES;
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
    localparam logic [SEQ_W-1:0] TIMEOUT_LAST = SEQ_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SEQ_W-1:0] RELEASE_LAST = SEQ_W'(RELEASE_CYCLES - 1);
    localparam logic [3:0]       MAX_ROWS_L   = 4'(MAX_ROWS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_RELEASE,
        S_FINISH,
        S_DRAIN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [SEQ_W-1:0] seq_cnt;
    logic [3:0]       row_limit;
    logic [3:0]       cur_row;
    logic [3:0]       limit_next;
    logic             go_accept;
    logic             row_done;
    logic             row_advance;
    logic             timeout_hit;
    logic             abort_hit;
    logic             timed_out;
    logic             last_row;

    assign ctrl_which_row = cur_row;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the single-cycle event strobes that drive the
    // status registers.
    // The abort and timeout checks come before the normal ctrl_done
    // transitions. A row that finishes in the same cycle as an abort or a
    // timeout is therefore not counted.
    // seq_cnt is shared between the wait timeout and the release/drain hold,
    // because only one of them is active in any state.
    always_comb begin
        state_next  = state;
        go_accept   = 1'b0;
        row_done    = 1'b0;
        row_advance = 1'b0;
        timeout_hit = 1'b0;
        abort_hit   = 1'b0;
        limit_next  = (num_rows > MAX_ROWS_L) ? MAX_ROWS_L : num_rows;
        timed_out   = (seq_cnt == TIMEOUT_LAST);
        last_row    = (cur_row == (row_limit - 4'd1));

        case (state)
            S_IDLE: begin
                if (go) begin
                    go_accept  = 1'b1;
                    state_next = (limit_next == 4'd0) ? S_FINISH : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (abort) begin
                    abort_hit  = 1'b1;
                    state_next = S_DRAIN;
                end else if (timed_out) begin
                    timeout_hit = 1'b1;
                    state_next  = S_DRAIN;
                end else if (!ctrl_done) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    abort_hit  = 1'b1;
                    state_next = S_DRAIN;
                end else if (timed_out) begin
                    timeout_hit = 1'b1;
                    state_next  = S_DRAIN;
                end else if (ctrl_done) begin
                    row_done   = 1'b1;
                    state_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (abort) begin
                    abort_hit  = 1'b1;
                    state_next = S_DRAIN;
                end else if (seq_cnt == RELEASE_LAST) begin
                    if (last_row) begin
                        state_next = S_FINISH;
                    end else begin
                        row_advance = 1'b1;
                        state_next  = S_LAUNCH;
                    end
                end
            end
            S_FINISH: begin
                state_next = S_IDLE;
            end
            S_DRAIN: begin
                if (seq_cnt == RELEASE_LAST) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Per-state cycle counter. It restarts on every state change, so in
    // LAUNCH and RUN it measures the wait time. In RELEASE and DRAIN it
    // measures the ctrl_start low time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_cnt <= '0;
        end else if (state_next != state) begin
            seq_cnt <= '0;
        end else if (state inside {S_LAUNCH, S_RUN, S_RELEASE, S_DRAIN}) begin
            seq_cnt <= seq_cnt + 1'b1;
        end
    end

    // ctrl_start and busy are decoded from the next state. This keeps them
    // registered while still making them track the state they belong to
    // with no extra cycle of lag.
    // all_done is registered from FINISH. It therefore pulses on the cycle
    // the block returns to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_start <= 1'b0;
            busy       <= 1'b0;
            all_done   <= 1'b0;
        end else begin
            ctrl_start <= (state_next == S_LAUNCH) || (state_next == S_RUN);
            busy       <= (state_next != S_IDLE);
            all_done   <= (state == S_FINISH);
        end
    end

    // Operation bookkeeping. An accepted go wipes the results of the
    // previous operation. At any other time the counters and sticky flags
    // only move on their event strobes.
    // cur_row is updated only on go or on leaving RELEASE. Both happen while
    // ctrl_start is low, so the row index never changes under a start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_limit      <= '0;
            cur_row        <= '0;
            rows_completed <= '0;
            cycle_count    <= '0;
            timeout_err    <= 1'b0;
            aborted        <= 1'b0;
        end else if (go_accept) begin
            row_limit      <= limit_next;
            cur_row        <= '0;
            rows_completed <= '0;
            cycle_count    <= '0;
            timeout_err    <= 1'b0;
            aborted        <= 1'b0;
        end else begin
            if (busy && (cycle_count != {CNT_W{1'b1}})) begin
                cycle_count <= cycle_count + 1'b1;
            end
            if (row_done) begin
                rows_completed <= rows_completed + 4'd1;
            end
            if (row_advance) begin
                cur_row <= cur_row + 4'd1;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
            if (abort_hit) begin
                aborted <= 1'b1;
            end
        end
    end

endmodule
